// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin handshake arbiter.
// Optional feature macro: ARB_BURST_LIMIT_EN (consumed by rr_handshake_arbiter).
package arb_pkg;

  localparam int MAX_PORTS = 16;
  localparam int MAX_IDX_W = 4;

  // Arbiter state: idle flag plus owner index (owner is meaningful only when idle=0)
  typedef struct packed {
    logic                 idle;
    logic [MAX_IDX_W-1:0] owner;
  } arb_state_t;

  localparam logic [MAX_IDX_W:0] ARB_IDLE = 5'b1_0000;

  // One-hot of idx within an n-port vector; indices at or above n give zero
  function automatic logic [MAX_PORTS-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx,
                                                         input int n);
    logic [MAX_PORTS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if ((i < n) && (idx == i[MAX_IDX_W-1:0])) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating priority encoder: first set bit of (req & ~excl) scanning
// start, start+1, ... modulo N.
module arb_rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic [N-1:0]     excl,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] eff;
  logic [IDX_W:0] cand;

  assign eff = req & ~excl;

  // Walk the rotation order once and latch the first eligible port
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, start} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!found && eff[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Sticky round-robin output-port arbiter with registered RTS / DCTS handshake.
// Optional feature macro: ARB_BURST_LIMIT_EN -- caps consecutive handshakes
// per owner at MAX_BURST while another port is waiting.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no owner, xbar_sel all zero, rts falls
//   OWN(k)   | port k owns the crossbar, rts toggles around each flit
module rr_handshake_arbiter
  import arb_pkg::*;
#(
  parameter int N_PORTS   = 5,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = $clog2(N_PORTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic               dcts,
  output logic [N_PORTS-1:0] grant,
  output logic [N_PORTS-1:0] xbar_sel,
  output logic               rts
);

  if ((N_PORTS < 2) || (N_PORTS > MAX_PORTS) || (MAX_BURST < 1)) begin : g_bad_param
    $error("rr_handshake_arbiter: N_PORTS must be 2..16 and MAX_BURST >= 1");
  end

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_inc, own_idx, start_idx, pick_idx;
  logic [N_PORTS-1:0] own_oh, excl;
  logic               rts_q, hs, hold, pick_found;

  assign own_oh    = N_PORTS'(idx_to_onehot(state_q.owner, N_PORTS));
  assign own_idx   = state_q.owner[IDX_W-1:0];
  assign last_inc  = (last_q == IDX_W'(N_PORTS-1)) ? '0 : last_q + IDX_W'(1);
  // From OWN(k) the scan starts at k itself, so a still-requesting owner wins first
  assign start_idx = state_q.idle ? last_inc : own_idx;
  assign hs        = rts_q & dcts;
  assign hold      = rts_q & ~dcts;

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST+1);
  logic [CNT_W-1:0] burst_q;
  logic             others, force_rot;

  assign others    = |(req & ~own_oh);
  assign force_rot = !state_q.idle && (burst_q == CNT_W'(MAX_BURST)) && others;
  assign excl      = force_rot ? own_oh : '0;

  // Count handshakes of the current owner; clear on any owner change or idle
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= '0;
    end else if (!hold) begin
      if (state_d.idle || state_q.idle || (state_d.owner != state_q.owner))
        burst_q <= '0;
      else if (hs && (burst_q != CNT_W'(MAX_BURST)))
        burst_q <= burst_q + CNT_W'(1);
    end
  end
`else
  assign excl = '0;
`endif

  arb_rr_pick #(.N(N_PORTS), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .start (start_idx),
    .excl  (excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state selection from the single shared scan
  always_comb begin
    state_d = arb_state_t'(ARB_IDLE);
    if (pick_found) begin
      state_d.idle  = 1'b0;
      state_d.owner = MAX_IDX_W'(pick_idx);
    end
  end

  // State, last owner and rts; everything freezes while rts waits on dcts
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= arb_state_t'(ARB_IDLE);
      last_q  <= IDX_W'(N_PORTS-1);
      rts_q   <= 1'b0;
    end else if (!hold) begin
      state_q <= state_d;
      if (!state_d.idle) last_q <= state_d.owner[IDX_W-1:0];
      rts_q   <= !state_q.idle && !hs;
    end
  end

  assign rts      = rts_q;
  assign xbar_sel = state_q.idle ? '0 : own_oh;
  assign grant    = (hs && !state_q.idle) ? own_oh : '0;

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
module tb_rr_handshake_arbiter;

  localparam int N  = 5;
  localparam int MB = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         dcts = 1'b0;
  logic [N-1:0] grant, xbar_sel;
  logic         rts;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // reference model: owner (-1 = idle), last owner, rts, burst count
  int m_own  = -1;
  int m_last = N-1;
  int m_rts  = 0;
  int m_cnt  = 0;

  int gq[$];
  int exp_seq[6];

  rr_handshake_arbiter #(.N_PORTS(N), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dcts     (dcts),
    .grant    (grant),
    .xbar_sel (xbar_sel),
    .rts      (rts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int scan(input int start, input logic [N-1:0] r, input int skip);
    for (int d = 0; d < N; d++) begin
      int p;
      p = (start + d) % N;
      if (p != skip && r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic d, input logic rs);
    int nxt;
    bit hs;
    if (rs) begin
      m_own = -1; m_last = N-1; m_rts = 0; m_cnt = 0;
    end else if (!(m_rts == 1 && !d)) begin
      hs = (m_rts == 1) && d;
      if (m_own < 0) begin
        nxt = scan((m_last + 1) % N, r, -1);
      end else begin
`ifdef ARB_BURST_LIMIT_EN
        if (m_cnt == MB && scan(m_own + 1, r, m_own) >= 0) nxt = scan(m_own + 1, r, m_own);
        else if (r[m_own]) nxt = m_own;
        else nxt = scan(m_own + 1, r, -1);
`else
        if (r[m_own]) nxt = m_own;
        else nxt = scan(m_own + 1, r, -1);
`endif
      end
      if (nxt < 0 || nxt != m_own) m_cnt = 0;
      else if (hs && m_cnt < MB) m_cnt++;
      m_rts = (m_own >= 0 && !hs) ? 1 : 0;
      m_own = nxt;
      if (nxt >= 0) m_last = nxt;
    end
  endtask

  task automatic model_check();
    logic [15:0] ex, eg;
    ex = (m_own >= 0) ? 16'(1 << m_own) : 16'h0;
    eg = (m_own >= 0 && m_rts == 1 && dcts) ? ex : 16'h0;
    chk("model_xbar", 16'(xbar_sel), ex);
    chk("model_grant", 16'(grant), eg);
    chk("model_rts", 16'(rts), 16'(m_rts));
  endtask

  task automatic apply(input logic [N-1:0] r, input logic d, input logic rs);
    req = r; dcts = d; rst = rs;
    #1;
    if (chk_en) model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step(req, dcts, rst);
    @(negedge clk);
  endtask

  initial begin
`ifdef ARB_BURST_LIMIT_EN
    exp_seq = '{0, 0, 1, 1, 0, 0};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
    @(negedge clk);
    apply(5'b00000, 1'b0, 1'b1); adv();
    chk_en = 1'b1;
    apply(5'b00000, 1'b0, 1'b1); adv();

    // reset state and first arbitration latency
    apply(5'b00110, 1'b1, 1'b0);
    chk("rst_xbar", 16'(xbar_sel), 16'h0);
    chk("rst_rts", 16'(rts), 16'h0);
    chk("rst_grant", 16'(grant), 16'h0);
    adv();
    apply(5'b00110, 1'b1, 1'b0);
    chk("t1_xbar", 16'(xbar_sel), 16'(5'b00010));
    chk("t1_rts_low", 16'(rts), 16'h0);
    adv();
    apply(5'b00110, 1'b1, 1'b0);
    chk("t1_rts", 16'(rts), 16'h1);
    chk("t1_grant", 16'(grant), 16'(5'b00010));
    adv();
    apply(5'b00110, 1'b1, 1'b0);
    chk("t1_rts_drop", 16'(rts), 16'h0);
    chk("t1_grant_drop", 16'(grant), 16'h0);
    adv();

    // dcts stall: frozen state, no grant, then a single pulse
    for (int i = 0; i < 5; i++) begin
      apply(5'b00010, 1'b0, 1'b0);
      chk("t2_rts", 16'(rts), 16'h1);
      chk("t2_grant", 16'(grant), 16'h0);
      chk("t2_xbar", 16'(xbar_sel), 16'(5'b00010));
      adv();
    end
    apply(5'b00010, 1'b1, 1'b0);
    chk("t2_pulse", 16'(grant), 16'(5'b00010));
    adv();
    apply(5'b10000, 1'b1, 1'b0);
    chk("t2_pulse_end", 16'(grant), 16'h0);
    adv();

    // owner 4 releases, wrap to port 0
    apply(5'b00011, 1'b1, 1'b0);
    chk("t3_xbar4", 16'(xbar_sel), 16'(5'b10000));
    chk("t3_grant4", 16'(grant), 16'(5'b10000));
    adv();
    apply(5'b00100, 1'b0, 1'b0);
    chk("t3_wrap", 16'(xbar_sel), 16'(5'b00001));
    adv();

    // idle after owner 2, all request -> port 3
    apply(5'b00000, 1'b1, 1'b0);
    chk("t4_xbar2", 16'(xbar_sel), 16'(5'b00100));
    chk("t4_grant2", 16'(grant), 16'(5'b00100));
    adv();
    apply(5'b11111, 1'b0, 1'b0);
    chk("t4_idle", 16'(xbar_sel), 16'h0);
    adv();
    apply(5'b11111, 1'b0, 1'b0);
    chk("t4_rot", 16'(xbar_sel), 16'(5'b01000));
    adv();

    // burst behaviour with two steady requesters
    apply(5'b00000, 1'b0, 1'b1); adv();
    for (int i = 0; i < 30 && gq.size() < 6; i++) begin
      apply(5'b00011, 1'b1, 1'b0);
      for (int b = 0; b < N; b++) if (grant[b]) gq.push_back(b);
      adv();
    end
    chk("t5_count", 16'(gq.size()), 16'd6);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      chk("t5_seq", 16'(gq[i]), 16'(exp_seq[i]));

    // reset mid-handshake
    apply(5'b00000, 1'b0, 1'b1); adv();
    apply(5'b00100, 1'b0, 1'b0); adv();
    apply(5'b00100, 1'b0, 1'b0); adv();
    apply(5'b00100, 1'b0, 1'b1);
    chk("t6_pre_rts", 16'(rts), 16'h1);
    adv();
    apply(5'b00011, 1'b1, 1'b0);
    chk("t6_rts", 16'(rts), 16'h0);
    chk("t6_xbar", 16'(xbar_sel), 16'h0);
    chk("t6_grant", 16'(grant), 16'h0);
    adv();
    apply(5'b00011, 1'b0, 1'b0);
    chk("t6_first", 16'(xbar_sel), 16'(5'b00001));
    adv();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      apply(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
